// File: rtl/noc_pkt_rx.sv
// noc_pkt_rx: NSU egress flit parser; checks head/tail framing, queues body data, reports a per-packet descriptor and sticky errors.
// Latency: a body flit reaches m_data two cycles after capture (holding register + FIFO); pkt_done follows the tail by one cycle.
// Backpressure: rx_busy is registered and rises at FIFO count >= FIFO_DEPTH-2; a push into a full FIFO is dropped and flags OVF.
// Optional: define RX_DEST_FILTER_EN to silently drop packets whose Dest_ID differs from LOCAL_ID.

module noc_pkt_rx_fifo #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 8,
  parameter int AF_LEVEL = 6
) (
  input  logic             noc_clk,
  input  logic             noc_rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_dat,
  output logic             empty,
  output logic             afull,
  output logic             ovf
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      cnt, cnt_nxt;
  logic             full, do_push, do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A pop in the same cycle frees the slot, so push at full is legal then.
  assign do_push = push & (~full | do_pop);
  assign ovf     = push & full & ~do_pop;
  assign cnt_nxt = cnt + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
  assign pop_dat = mem[rd_ptr];

  // Storage array; no reset needed since reads are qualified by empty.
  always_ff @(posedge noc_clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

  // Pointers, occupancy and the registered almost-full flag.
  always_ff @(posedge noc_clk or negedge noc_rst_n) begin
    if (!noc_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      afull  <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      cnt   <= cnt_nxt;
      afull <= (cnt_nxt >= (AW+1)'(AF_LEVEL));
    end
  end
endmodule

module noc_pkt_rx #(
  parameter int DATA_WIDTH     = 128,
  parameter int ID_WIDTH       = 4,
  parameter int VIRTUAL_CH_NUM = 16,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int FLIT_NUM_MAX   = 16,
  parameter int FIFO_DEPTH     = 8,
  parameter logic [ID_WIDTH-1:0] LOCAL_ID = 4'hF
) (
  input  logic                      noc_clk,
  input  logic                      noc_rst_n,
  input  logic [DATA_WIDTH:0]       s_flit,
  input  logic                      s_is_head,
  input  logic                      s_is_tail,
  output logic                      rx_busy,
  output logic [DATA_WIDTH-1:0]     m_data,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic                      m_last,
  output logic                      pkt_done,
  output logic                      pkt_ok,
  output logic [2:0]                pkt_type,
  output logic [ID_WIDTH-1:0]       pkt_src,
  output logic [VIRTUAL_CH_NUM-1:0] pkt_order,
  output logic [7:0]                pkt_len,
  output logic [AXI_ADDR_WIDTH-1:0] pkt_addr,
  output logic [AXI_ADDR_WIDTH-1:0] pkt_repack,
  output logic [5:0]                err,
  input  logic                      err_clr
);
  localparam logic [2:0] TYPE_RD_REQ = 3'b010;
  localparam logic [2:0] TYPE_BRESP  = 3'b011;
  localparam logic [3:0] HEAD_CODE_H = 4'h5;
  localparam logic [3:0] HEAD_CODE_E = 4'hA;
  localparam logic [3:0] TAIL_CODE_H = 4'h0;
  localparam logic [3:0] TAIL_CODE_E = 4'hF;

  // Field LSB positions, packed MSB-first from the top of the payload.
  localparam int L_CH  = DATA_WIDTH - 4;
  localparam int L_SRC = L_CH - ID_WIDTH;
  localparam int L_DST = L_SRC - ID_WIDTH;
  localparam int L_TYP = L_DST - 3;
  localparam int L_ORD = L_TYP - VIRTUAL_CH_NUM;
  localparam int L_LEN = L_ORD - 8;
  localparam int L_ADR = L_LEN - AXI_ADDR_WIDTH;
  localparam int L_CE  = L_ADR - 4;

  typedef enum logic [1:0] {ST_IDLE, ST_BODY, ST_DROP} state_t;
  state_t state, state_nxt;

  logic [3:0]                f_code_h, f_code_e;
  logic [ID_WIDTH-1:0]       f_src, f_dst, h_src, h_dst;
  logic [2:0]                f_type, h_type;
  logic [VIRTUAL_CH_NUM-1:0] f_order, h_order;
  logic [7:0]                f_len, h_len;
  logic [AXI_ADDR_WIDTH-1:0] f_addr, h_addr;
  logic                      pad_unused;

  assign f_code_h   = s_flit[L_CH  +: 4];
  assign f_src      = s_flit[L_SRC +: ID_WIDTH];
  assign f_dst      = s_flit[L_DST +: ID_WIDTH];
  assign f_type     = s_flit[L_TYP +: 3];
  assign f_order    = s_flit[L_ORD +: VIRTUAL_CH_NUM];
  assign f_len      = s_flit[L_LEN +: 8];
  assign f_addr     = s_flit[L_ADR +: AXI_ADDR_WIDTH];
  assign f_code_e   = s_flit[L_CE  +: 4];
  assign pad_unused = ^s_flit[L_CE-1:0];

  // A flit flagged both head and tail is treated as a head.
  logic is_head, is_tail, is_body;
  assign is_head = s_flit[DATA_WIDTH] & s_is_head;
  assign is_tail = s_flit[DATA_WIDTH] & ~s_is_head & s_is_tail;
  assign is_body = s_flit[DATA_WIDTH] & ~s_is_head & ~s_is_tail;

  logic head_code_ok, dst_is_local, dst_ok;
  assign head_code_ok = (f_code_h == HEAD_CODE_H) && (f_code_e == HEAD_CODE_E);
  assign dst_is_local = (f_dst == LOCAL_ID);
`ifdef RX_DEST_FILTER_EN
  assign dst_ok = dst_is_local;
`else
  logic dst_filter_unused;
  assign dst_filter_unused = dst_is_local;
  assign dst_ok = 1'b1;
`endif

  logic head_ld, body_acc, tail_acc, hold_close, set_hc, set_orph;

  // State register.
  always_ff @(posedge noc_clk or negedge noc_rst_n) begin
    if (!noc_rst_n) state <= ST_IDLE;
    else            state <= state_nxt;
  end

  // Next state and per-flit control; a head inside BODY aborts the open packet and restarts.
  always_comb begin
    state_nxt  = state;
    head_ld    = 1'b0;
    body_acc   = 1'b0;
    tail_acc   = 1'b0;
    hold_close = 1'b0;
    set_hc     = 1'b0;
    set_orph   = 1'b0;
    case (state)
      ST_IDLE, ST_BODY: begin
        if (is_head) begin
          hold_close = (state == ST_BODY);
          set_hc     = ~head_code_ok;
          head_ld    = head_code_ok & dst_ok;
          state_nxt  = (head_code_ok && dst_ok) ? ST_BODY : ST_DROP;
        end else if (state == ST_IDLE) begin
          set_orph = is_body | is_tail;
        end else if (is_body) begin
          body_acc = 1'b1;
        end else if (is_tail) begin
          tail_acc  = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      ST_DROP: if (is_tail) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Tail checks against the latched head.
  logic [4:0] body_cnt, exp_cnt;
  logic       tcode_bad, mism, len_bad;
  assign tcode_bad = (f_code_h != TAIL_CODE_H) || (f_code_e != TAIL_CODE_E);
  assign mism      = (f_src != h_src) || (f_dst != h_dst) || (f_type != h_type) || (f_len != h_len);
  assign len_bad   = (body_cnt != exp_cnt);

  // Expected body count: fixed for RD_REQ/BRESP, len-derived for the final packet, full otherwise.
  always_comb begin
    exp_cnt = 5'(FLIT_NUM_MAX);
    if (h_type == TYPE_RD_REQ)     exp_cnt = 5'd1;
    else if (h_type == TYPE_BRESP) exp_cnt = 5'd0;
    else if (h_order == f_order)   exp_cnt = {1'b0, h_len[3:0]} + 5'd1;
  end

  // Head field latch.
  always_ff @(posedge noc_clk or negedge noc_rst_n) begin
    if (!noc_rst_n) begin
      h_src <= '0; h_dst <= '0; h_type <= '0; h_order <= '0; h_len <= '0; h_addr <= '0;
    end else if (head_ld) begin
      h_src <= f_src; h_dst <= f_dst; h_type <= f_type; h_order <= f_order; h_len <= f_len; h_addr <= f_addr;
    end
  end

  // Saturating body-flit counter for the open packet.
  always_ff @(posedge noc_clk or negedge noc_rst_n) begin
    if (!noc_rst_n)                       body_cnt <= '0;
    else if (head_ld)                     body_cnt <= '0;
    else if (body_acc && body_cnt != '1)  body_cnt <= body_cnt + 5'd1;
  end

  // One-entry holding register: the newest body flit waits here until we know whether it is the last.
  logic                  hold_vld, fifo_push, fifo_ovf, fifo_empty;
  logic [DATA_WIDTH-1:0] hold_dat;
  assign fifo_push = hold_vld & (body_acc | tail_acc | hold_close);

  always_ff @(posedge noc_clk or negedge noc_rst_n) begin
    if (!noc_rst_n) begin
      hold_vld <= 1'b0;
      hold_dat <= '0;
    end else if (body_acc) begin
      hold_vld <= 1'b1;
      hold_dat <= s_flit[DATA_WIDTH-1:0];
    end else if (tail_acc || hold_close) begin
      hold_vld <= 1'b0;
    end
  end

  // An aborted packet's final flit is also marked last so consumers stay framed.
  noc_pkt_rx_fifo #(.WIDTH(DATA_WIDTH+1), .DEPTH(FIFO_DEPTH), .AF_LEVEL(FIFO_DEPTH-2)) u_fifo (
    .noc_clk   (noc_clk),
    .noc_rst_n (noc_rst_n),
    .push      (fifo_push),
    .push_dat  ({tail_acc | hold_close, hold_dat}),
    .pop       (m_ready),
    .pop_dat   ({m_last, m_data}),
    .empty     (fifo_empty),
    .afull     (rx_busy),
    .ovf       (fifo_ovf)
  );
  assign m_valid = ~fifo_empty;

  // Per-packet error memory so pkt_ok also reflects overflows seen mid-packet.
  logic pkt_bad;
  always_ff @(posedge noc_clk or negedge noc_rst_n) begin
    if (!noc_rst_n)                         pkt_bad <= 1'b0;
    else if (head_ld)                       pkt_bad <= 1'b0;
    else if (state == ST_BODY && fifo_ovf)  pkt_bad <= 1'b1;
  end

  // Descriptor outputs, published with the pkt_done pulse.
  always_ff @(posedge noc_clk or negedge noc_rst_n) begin
    if (!noc_rst_n) begin
      pkt_done <= 1'b0; pkt_ok <= 1'b0; pkt_type <= '0; pkt_src <= '0;
      pkt_order <= '0; pkt_len <= '0; pkt_addr <= '0; pkt_repack <= '0;
    end else begin
      pkt_done <= tail_acc;
      pkt_ok   <= tail_acc & ~(pkt_bad | fifo_ovf | len_bad | mism | tcode_bad);
      if (tail_acc) begin
        pkt_type <= h_type; pkt_src <= h_src; pkt_order <= h_order;
        pkt_len <= h_len; pkt_addr <= h_addr; pkt_repack <= f_addr;
      end
    end
  end

  // Sticky error flags {OVF, ORPHAN, LEN, MISMATCH, TAIL_CODE, HEAD_CODE}; clear beats set.
  logic [5:0] err_set;
  assign err_set = {fifo_ovf, set_orph, (tail_acc & len_bad) | hold_close,
                    tail_acc & mism, tail_acc & tcode_bad, set_hc};
  always_ff @(posedge noc_clk or negedge noc_rst_n) begin
    if (!noc_rst_n)   err <= '0;
    else if (err_clr) err <= '0;
    else              err <= err | err_set;
  end
endmodule

// File: doc/noc_pkt_rx.md
Name: noc_pkt_rx

Overview:
- Receive-side packet parser at the NoC egress of the NSU: consumes flits in the NMU/NSU wire format and undoes the framing the flit generators apply.
- Head flit: [HEAD_CODE_H, Source_ID, Dest_ID, TYPE, PACK_ORDER, AXI_LEN, AXI_ADDR, HEAD_CODE_E, zero pad].
- Tail flit: [TAIL_CODE_H, Source_ID, Dest_ID, TYPE, PACK_NUM, AXI_LEN, RE_PACK, TAIL_CODE_E, zero pad].
- Validates framing, buffers body data in an 8-entry FIFO with busy backpressure, and emits a per-packet descriptor plus sticky error flags for checkers and AXI-side consumers.

Parameters:
- DATA_WIDTH, 128, flit payload width; flit bus is DATA_WIDTH+1 bits, MSB = valid.
- ID_WIDTH, 4, Source_ID/Dest_ID width.
- VIRTUAL_CH_NUM, 16, PACK_ORDER/PACK_NUM one-hot width.
- AXI_ADDR_WIDTH, 32, AXI_ADDR/RE_PACK width.
- FLIT_NUM_MAX, 16, body flits in every non-final packet.
- FIFO_DEPTH, 8, body FIFO entries (power of two).
- LOCAL_ID, 4'hF, this node's ID (used only with RX_DEST_FILTER_EN).
- TYPE_WRITE 3'b100, TYPE_RD_REQ 3'b010, TYPE_BRESP 3'b011, TYPE_RD_DATA 3'b001.
- HEAD_CODE_H 4'h5, HEAD_CODE_E 4'hA, TAIL_CODE_H 4'h0, TAIL_CODE_E 4'hF.

Ports:
- noc_clk  in  1  clock
- noc_rst_n  in  1  asynchronous active-low reset
- s_flit  in  DATA_WIDTH+1  flit bus; bit DATA_WIDTH = flit valid
- s_is_head  in  1  qualifies a head flit
- s_is_tail  in  1  qualifies a tail flit
- rx_busy  out  1  backpressure to sender
- m_data  out  DATA_WIDTH  body data out
- m_valid  out  1  m_data valid
- m_ready  in  1  consumer accept
- m_last  out  1  last body flit of the packet
- pkt_done  out  1  one-cycle pulse on tail acceptance
- pkt_ok  out  1  no error in the completed packet; valid with pkt_done
- pkt_type  out  3  TYPE from the head flit
- pkt_src  out  ID_WIDTH  Source_ID from the head flit
- pkt_order  out  VIRTUAL_CH_NUM  PACK_ORDER from the head flit
- pkt_len  out  8  AXI_LEN from the head flit
- pkt_addr  out  AXI_ADDR_WIDTH  AXI_ADDR from the head flit
- pkt_repack  out  AXI_ADDR_WIDTH  RE_PACK from the tail flit
- err  out  6  sticky errors {OVF, ORPHAN, LEN, MISMATCH, TAIL_CODE, HEAD_CODE}
- err_clr  in  1  synchronous clear of err

Behaviour:
- Reset: all outputs 0; FSM IDLE; FIFO empty; counters 0.
- Field slices, MSB-first from bit DATA_WIDTH-1: code_h[4], src[ID], dst[ID], type[3], order/num[VC], len[8], addr/repack[ADDR], code_e[4].
- Flit accepted: s_flit[DATA_WIDTH]=1. Sender honours rx_busy with one cycle of latency.
- rx_busy is registered, =1 when FIFO count >= FIFO_DEPTH-2. This keeps two slots of skid space.
- FSM IDLE:
  - Head flit: latch head fields, clear body count, go BODY.
  - Bad head code: set HEAD_CODE, go DROP.
  - Body or tail flit: set ORPHAN, stay IDLE.
- FSM BODY:
  - Body flit: push to FIFO, increment body count (5-bit, saturating at 31).
  - Tail flit: run tail checks, pulse pkt_done next cycle, go IDLE.
  - Head flit: set LEN, restart with the new head.
- FSM DROP: discard all flits until a tail, then go IDLE; no pkt_done.
- Tail checks:
  - Tail codes wrong: set TAIL_CODE.
  - src/dst/type/len differ from the head: set MISMATCH.
  - Body count wrong: set LEN. Expected count:
    - RD_REQ: 1.
    - BRESP: 0.
    - Otherwise, PACK_ORDER==PACK_NUM: len[3:0]+1.
    - Otherwise: FLIT_NUM_MAX.
- pkt_ok = no error set during this packet.
- m_last marks the FIFO entry pushed last before the tail. It is tagged retroactively through a one-entry holding register, so FIFO latency is 1 extra cycle.
- FIFO: m_valid = not empty; pop on m_valid & m_ready.
  - Simultaneous push and pop at full is allowed.
  - Push while full: drop the flit, set OVF.
- err: sticky. err_clr wins over a same-cycle set.
- Asynchronous reset mid-packet returns to IDLE and empties the FIFO.

Optional Feature:
- RX_DEST_FILTER_EN defined: a head with dst != LOCAL_ID sends the FSM to DROP without setting any error.
- Macro absent: dst is not compared against anything.

Test Plan:
- Final WRITE packet (order = num = 16'h0004, len 8'h29, addr 32'h2000, 10 body flits data 1..10) -> m_data 1..10, m_last on 10, pkt_done with pkt_ok=1, pkt_addr=32'h2000, pkt_repack=32'h0040_007f.
- RD_REQ with 1 body flit of all-ones -> pkt_ok=1, pkt_type=3'b010, err=0.
- Non-final WRITE (order 16'h0001, num 16'h0004) with 15 body flits -> err[LEN]=1, pkt_ok=0.
- Tail flit in IDLE -> err[ORPHAN]=1, no pkt_done. err_clr -> err=0.
- m_ready=0 during 16 body flits with the sender obeying rx_busy -> rx_busy high at count 6, no OVF. Release m_ready -> all 16 flits emerge in order.
- Head with HEAD_CODE_E=4'hB followed by body and tail flits -> err[HEAD_CODE]=1, FIFO unchanged, no pkt_done.
